// File: rtl/con_writer.sv
// rtl/con_writer.sv - 80x50 text console writer: character put, clear and scroll over a VRAM port
module con_writer #(
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CH_VALID,
  output logic        CH_READY,
  input  logic [7:0]  CH_DATA,
  input  logic [11:0] COLOR,
  output logic [15:0] WRADDR,
  output logic [3:0]  BYTEEN,
  output logic        WREN,
  output logic [31:0] WRDATA,
  output logic [15:0] RDADDR,
  output logic        RDEN,
  input  logic [31:0] RDDATA,
  output logic [6:0]  CUR_COL,
  output logic [5:0]  CUR_ROW,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    INIT_CLR, IDLE, PUT, CLR, SCR_RD, SCR_WAIT, SCR_WR, SCR_FILL
  } state_t;

  localparam logic [11:0] LAST_IDX   = 12'd3999;
  localparam logic [11:0] LAST_SCR   = 12'd3919;
  localparam logic [11:0] ROW_WORDS  = 12'd80;
  localparam logic [31:0] SPACE_WORD = 32'h0000_0020;
  // Final SCR_WAIT count; only reachable when RD_LATENCY > 1.
  localparam logic [1:0]  WAIT_LAST  = 2'(RD_LATENCY - 2);

  state_t      state_q, state_d;
  logic [11:0] idx_q, idx_d;
  logic [1:0]  wait_q, wait_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [7:0]  ch_q, ch_d;
  logic [11:0] color_q, color_d;

  logic        printable;
  logic        start_scroll;
  logic [11:0] cur_idx;
  logic        unused_rddata;

  assign printable     = (ch_q >= 8'h20) && (ch_q <= 8'h7E);
  assign cur_idx       = {6'd0, row_q} * ROW_WORDS + {5'd0, col_q};
  assign unused_rddata = ^RDDATA[31:20];

  function automatic logic [15:0] byte_addr(input logic [11:0] idx);
    return {2'b00, idx, 2'b00};
  endfunction

  // State, index and cursor registers; reset aborts any clear/scroll in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR_ON_RESET ? INIT_CLR : IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      color_q <= color_d;
    end
  end

  // Next state: decode the captured code, sequence clear and scroll word loops.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    col_d        = col_q;
    row_d        = row_q;
    ch_d         = ch_q;
    color_d      = color_q;
    start_scroll = 1'b0;
    case (state_q)
      IDLE: begin
        if (CH_VALID) begin
          ch_d    = CH_DATA;
          color_d = COLOR;
          state_d = PUT;
        end
      end
      PUT: begin
        state_d = IDLE;
        if (printable) begin
          if (col_q != 7'd79) begin
            col_d = col_q + 7'd1;
          end else if (row_q != 6'd49) begin
            col_d = '0;
            row_d = row_q + 6'd1;
          end else begin
            start_scroll = 1'b1;
          end
        end else begin
          case (ch_q)
            8'h0A: begin
              if (row_q != 6'd49) begin
                col_d = '0;
                row_d = row_q + 6'd1;
              end else begin
                start_scroll = 1'b1;
              end
            end
            8'h0D: col_d = '0;
            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h0C: begin
              state_d = CLR;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
        // Cursor stays put during the scroll; it lands on (49,0) at the end.
        if (start_scroll) begin
          state_d = SCR_RD;
          idx_d   = '0;
        end
      end
      INIT_CLR, CLR: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          idx_d = idx_q + 12'd1;
        end
      end
      SCR_RD: begin
        wait_d  = '0;
        state_d = (RD_LATENCY > 1) ? SCR_WAIT : SCR_WR;
      end
      SCR_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = SCR_WR;
        else                     wait_d  = wait_q + 2'd1;
      end
      SCR_WR: begin
        idx_d   = idx_q + 12'd1;
        state_d = (idx_q == LAST_SCR) ? SCR_FILL : SCR_RD;
      end
      SCR_FILL: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = 6'd49;
        end else begin
          idx_d = idx_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; everything is forced quiet while RST is high.
  always_comb begin
    CH_READY = 1'b0;
    WREN     = 1'b0;
    RDEN     = 1'b0;
    BUSY     = 1'b0;
    WRADDR   = '0;
    RDADDR   = '0;
    WRDATA   = '0;
    BYTEEN   = '0;
    CUR_COL  = '0;
    CUR_ROW  = '0;
    if (!RST) begin
      CUR_COL = col_q;
      CUR_ROW = row_q;
      case (state_q)
        IDLE: CH_READY = 1'b1;
        PUT: begin
          if (printable) begin
            WREN   = 1'b1;
            WRADDR = byte_addr(cur_idx);
            WRDATA = {12'h000, color_q, 1'b0, ch_q[6:0]};
          end
        end
        INIT_CLR, CLR, SCR_FILL: begin
          BUSY   = 1'b1;
          WREN   = 1'b1;
          WRADDR = byte_addr(idx_q);
          WRDATA = SPACE_WORD;
        end
        SCR_RD: begin
          BUSY   = 1'b1;
          RDEN   = 1'b1;
          RDADDR = byte_addr(idx_q + ROW_WORDS);
        end
        SCR_WAIT: BUSY = 1'b1;
        SCR_WR: begin
          BUSY   = 1'b1;
          WREN   = 1'b1;
          WRADDR = byte_addr(idx_q);
          WRDATA = {12'h000, RDDATA[19:0]};
        end
        default: ;
      endcase
      if (WREN) BYTEEN = 4'b0111;
    end
  end

endmodule

// File: tb/tb_con_writer.sv
// tb/tb_con_writer.sv - randomized bench for con_writer against a screen-level model
module tb_con_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CH_VALID = 1'b0;
  logic        CH_READY;
  logic [7:0]  CH_DATA = '0;
  logic [11:0] COLOR = '0;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WRDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDDATA = '0;
  logic [6:0]  CUR_COL;
  logic [5:0]  CUR_ROW;
  logic        BUSY;

  always #5 CLK = ~CLK;

  con_writer #(.RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RST(RST), .CH_VALID(CH_VALID), .CH_READY(CH_READY),
    .CH_DATA(CH_DATA), .COLOR(COLOR), .WRADDR(WRADDR), .BYTEEN(BYTEEN),
    .WREN(WREN), .WRDATA(WRDATA), .RDADDR(RDADDR), .RDEN(RDEN),
    .RDDATA(RDDATA), .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW), .BUSY(BUSY)
  );

  // VRAM with one cycle of read latency
  logic [31:0] mem [0:4095];
  always @(posedge CLK) begin
    if (WREN) mem[WRADDR[13:2]] <= WRDATA;
    if (RDEN) RDDATA <= mem[RDADDR[13:2]];
  end

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int wr_total = 0;

  // Screen model: expected VRAM words, cursor and expected strobe streams
  logic [31:0] scr [0:3999];
  int mcol = 0;
  int mrow = 0;
  logic [47:0] exp_wr[$];
  logic [15:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] baddr(input int idx);
    return 16'(idx * 4);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4000; i++) begin
      exp_wr.push_back({baddr(i), 32'h0000_0020});
      scr[i] = 32'h0000_0020;
    end
  endtask

  task automatic model_scroll();
    logic [31:0] w;
    for (int i = 0; i < 3920; i++) begin
      w = {12'h000, scr[i + 80][19:0]};
      exp_rd.push_back(baddr(i + 80));
      exp_wr.push_back({baddr(i), w});
      scr[i] = w;
    end
    for (int i = 3920; i < 4000; i++) begin
      exp_wr.push_back({baddr(i), 32'h0000_0020});
      scr[i] = 32'h0000_0020;
    end
    mrow = 49;
    mcol = 0;
  endtask

  task automatic model_apply(input logic [7:0] ch, input logic [11:0] color, output int busy);
    int idx;
    logic [31:0] w;
    busy = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      idx = mrow * 80 + mcol;
      w = {12'h000, color, 1'b0, ch[6:0]};
      exp_wr.push_back({baddr(idx), w});
      scr[idx] = w;
      if (mcol < 79) mcol++;
      else begin
        mcol = 0;
        if (mrow < 49) mrow++;
        else begin model_scroll(); busy = 7920; end
      end
    end else if (ch == 8'h0A) begin
      mcol = 0;
      if (mrow < 49) mrow++;
      else begin model_scroll(); busy = 7920; end
    end else if (ch == 8'h0D) begin
      mcol = 0;
    end else if (ch == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (ch == 8'h0C) begin
      model_clear();
      mcol = 0;
      mrow = 0;
      busy = 4000;
    end
  endtask

  // Per-cycle compare of DUT outputs against the model streams and cursor
  logic [47:0] e_wr;
  logic [15:0] e_rd;
  logic [6:0]  pcol;
  logic [5:0]  prow;
  logic        pbusy = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      check("reset_ctl", {16'd0, WREN, RDEN, CH_READY, BUSY, BYTEEN, CUR_COL, CUR_ROW}, 32'd0);
      check("reset_addr", {WRADDR, RDADDR}, 32'd0);
      check("reset_wrdata", WRDATA, 32'd0);
    end else begin
      check("rd_wr_overlap", {31'd0, WREN & RDEN}, 32'd0);
      if (WREN) begin
        wr_total++;
        check("byteen", {28'd0, BYTEEN}, 32'h7);
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h data %h", WRADDR, WRDATA);
        end else begin
          e_wr = exp_wr.pop_front();
          check("wr_addr", {16'd0, WRADDR}, {16'd0, e_wr[47:32]});
          check("wr_data", WRDATA, e_wr[31:0]);
        end
      end
      if (RDEN) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %h", RDADDR);
        end else begin
          e_rd = exp_rd.pop_front();
          check("rd_addr", {16'd0, RDADDR}, {16'd0, e_rd});
        end
      end
      if (BUSY) busy_cnt++;
      if (CH_READY) begin
        check("cur_col", {25'd0, CUR_COL}, 32'(mcol));
        check("cur_row", {26'd0, CUR_ROW}, 32'(mrow));
      end
      if (BUSY && pbusy) check("cursor_stable_busy", {19'd0, CUR_COL, CUR_ROW}, {19'd0, pcol, prow});
    end
    pcol  = CUR_COL;
    prow  = CUR_ROW;
    pbusy = BUSY && !RST;
  end

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (!CH_READY && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic send(input logic [7:0] ch, input logic [11:0] color);
    int n, busy_exp, b0;
    wait_ready(10, n);
    check("ready_before_send", {31'd0, CH_READY}, 32'd1);
    CH_VALID = 1'b1;
    CH_DATA  = ch;
    COLOR    = color;
    b0 = busy_cnt;
    @(posedge CLK); #1;
    CH_VALID = 1'b0;
    CH_DATA  = 8'($urandom);
    COLOR    = 12'($urandom);
    model_apply(ch, color, busy_exp);
    wait_ready(busy_exp + 20, n);
    check("handshake_latency", n, 32'(1 + busy_exp));
    check("busy_cycles", busy_cnt - b0, 32'(busy_exp));
    check("wr_stream_drained", exp_wr.size(), 32'd0);
    check("rd_stream_drained", exp_rd.size(), 32'd0);
  endtask

  task automatic compare_screen(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 4000; i++) if (mem[i] !== scr[i]) bad++;
    check(name, bad, 32'd0);
  endtask

  task automatic release_and_clear(input string name);
    int n, b0;
    model_clear();
    mcol = 0;
    mrow = 0;
    b0 = busy_cnt;
    RST = 1'b0;
    wait_ready(4100, n);
    check(name, n, 32'd4000);
    check("clear_busy", busy_cnt - b0, 32'd4000);
    check("clear_drained", exp_wr.size(), 32'd0);
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    logic [7:0] c;
    r = $urandom_range(0, 99);
    if (r < 75) return 8'($urandom_range(32, 126));
    if (r < 85) return 8'h0A;
    if (r < 90) return 8'h0D;
    if (r < 95) return 8'h08;
    c = 8'($urandom);
    if ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C)
      c = 8'h7F;
    return c;
  endfunction

  initial begin
    int n, b0, w0, busy_dummy;
    repeat (3) @(posedge CLK);
    #1;
    release_and_clear("init_clear_cycles");
    check("mem_first_space", mem[0], 32'h0000_0020);
    check("mem_last_space", mem[3999], 32'h0000_0020);

    send(8'h41, 12'hF00);
    check("A_word", mem[0], 32'h000F_0041);
    check("A_cursor", {19'd0, CUR_COL, CUR_ROW}, {19'd0, 7'd1, 6'd0});

    send(8'h0D, 12'h000);
    repeat (10) send(8'h0A, 12'h000);
    repeat (79) send(8'($urandom_range(32, 126)), 12'($urandom));
    check("pre_B_cursor", {19'd0, CUR_COL, CUR_ROW}, {19'd0, 7'd79, 6'd10});
    send(8'h42, 12'h0A5);
    check("B_word", mem[879], 32'h0000_A542);
    check("B_cursor", {19'd0, CUR_COL, CUR_ROW}, {19'd0, 7'd0, 6'd11});

    while (mrow < 49) send(8'h0A, 12'h000);
    repeat (5) send(8'($urandom_range(32, 126)), 12'($urandom));
    check("pre_scroll_cursor", {19'd0, CUR_COL, CUR_ROW}, {19'd0, 7'd5, 6'd49});
    b0 = busy_cnt;
    send(8'h0A, 12'h000);
    check("scroll_busy_7920", busy_cnt - b0, 32'd7920);
    check("scroll_cursor", {19'd0, CUR_COL, CUR_ROW}, {19'd0, 7'd0, 6'd49});
    check("B_moved_up", mem[799], 32'h0000_A542);
    compare_screen("screen_after_scroll");

    w0 = wr_total;
    send(8'h08, 12'hFFF);
    send(8'h0D, 12'hFFF);
    send(8'h07, 12'hFFF);
    check("ctl_no_writes", wr_total - w0, 32'd0);
    check("ctl_cursor", {19'd0, CUR_COL, CUR_ROW}, {19'd0, 7'd0, 6'd49});

    send(8'h0C, 12'h123);
    check("ff_cursor", {19'd0, CUR_COL, CUR_ROW}, 32'd0);
    check("ff_space", mem[1234], 32'h0000_0020);

    repeat (250) send(rand_code(), 12'($urandom));
    compare_screen("screen_after_random");

    // Reset in the middle of a scroll
    while (mrow < 49) send(8'h0A, 12'h000);
    wait_ready(10, n);
    CH_VALID = 1'b1;
    CH_DATA  = 8'h0A;
    @(posedge CLK); #1;
    CH_VALID = 1'b0;
    model_apply(8'h0A, 12'h000, busy_dummy);
    w0 = wr_total;
    n = 0;
    while (wr_total - w0 < 100 && n < 1000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("scroll_word_100", wr_total - w0, 32'd100);
    RST = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    mcol = 0;
    mrow = 0;
    w0 = wr_total;
    repeat (3) begin @(posedge CLK); #1; end
    check("no_strobes_in_reset", wr_total - w0, 32'd0);
    release_and_clear("reclear_cycles");
    compare_screen("screen_after_reclear");

    send(8'h5A, 12'h123);
    check("Z_word", mem[0], 32'h0001_235A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
